// File: rtl/aud_capture_ch.sv
// rtl/aud_capture_ch.sv - I2S ADC capture engine feeding an SRAM write port
module aud_capture_ch #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 20
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_lrc,
    input  logic              i_data,
    input  logic [1:0]        i_mode,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    output logic [ADDR_W-1:0] o_address,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic [ADDR_W:0]   o_length,
    output logic [1:0]        o_state,
    output logic              o_fin
);
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] SLOT_DONE = CNT_W'(DATA_W);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_PAUSED  = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic              lrc_p;
    logic              fall_edge, rise_edge;
    logic [1:0]        mode_q;
    logic              left_en, right_en;
    logic              pause_pend, pause_now;
    logic [CNT_W-1:0]  bit_cnt;
    logic              slot_en;
    logic [DATA_W-1:0] shreg;
    logic [ADDR_W-1:0] next_addr;
    logic              word_done, do_write, full_hit, chan_start;

    assign fall_edge = lrc_p & ~i_lrc;
    assign rise_edge = ~lrc_p & i_lrc;
    assign left_en   = (mode_q != 2'd1);
    assign right_en  = (mode_q == 2'd1) || (mode_q == 2'd2);
    assign pause_now = pause_pend | i_pause;

    // Last bit of an enabled slot arrives this cycle; stop discards it.
    assign word_done = (state == S_CAPTURE) && slot_en && (bit_cnt == LAST_BIT)
                       && !fall_edge && !rise_edge;
    assign do_write  = word_done && !i_stop;
    assign full_hit  = do_write && (next_addr == {ADDR_W{1'b1}});

    assign o_state = state;

    always_comb begin
        state_nxt  = state;
        chan_start = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_start) state_nxt = S_ARMED;
            end
            S_ARMED: begin
                if (i_stop) begin
                    state_nxt = S_IDLE;
                end else if (i_pause) begin
                    state_nxt = S_PAUSED;
                end else if (fall_edge) begin
                    state_nxt  = S_CAPTURE;
                    chan_start = 1'b1;
                end
            end
            S_CAPTURE: begin
                // Pause only lands on a frame boundary so stereo pairs never split.
                if (i_stop || full_hit) begin
                    state_nxt = S_IDLE;
                end else if (fall_edge && pause_now) begin
                    state_nxt = S_PAUSED;
                end else if (fall_edge || rise_edge) begin
                    chan_start = 1'b1;
                end
            end
            S_PAUSED: begin
                if (i_stop) begin
                    state_nxt = S_IDLE;
                end else if (i_start) begin
                    state_nxt = S_ARMED;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lrc_p      <= 1'b0;
            mode_q     <= 2'd0;
            pause_pend <= 1'b0;
            bit_cnt    <= '0;
            slot_en    <= 1'b0;
            shreg      <= '0;
            next_addr  <= '0;
            o_address  <= '0;
            o_data     <= '0;
            o_valid    <= 1'b0;
            o_length   <= '0;
            o_fin      <= 1'b0;
        end else begin
            lrc_p   <= i_lrc;
            o_valid <= 1'b0;
            o_fin   <= 1'b0;

            if (state == S_IDLE && i_start) begin
                mode_q    <= (i_mode == 2'd3) ? 2'd0 : i_mode;
                next_addr <= '0;
                o_length  <= '0;
            end

            if (state_nxt == S_IDLE || state_nxt == S_PAUSED) begin
                pause_pend <= 1'b0;
            end else if (i_pause && (state == S_ARMED || state == S_CAPTURE)) begin
                pause_pend <= 1'b1;
            end

            if (chan_start) begin
                bit_cnt <= '0;
                slot_en <= fall_edge ? left_en : right_en;
            end else if (state_nxt != S_CAPTURE) begin
                slot_en <= 1'b0;
            end else if (slot_en && bit_cnt != SLOT_DONE) begin
                shreg   <= {shreg[DATA_W-2:0], i_data};
                bit_cnt <= bit_cnt + CNT_W'(1);
            end

            if (do_write) begin
                o_data    <= {shreg[DATA_W-2:0], i_data};
                o_address <= next_addr;
                o_length  <= {1'b0, next_addr} + (ADDR_W+1)'(1);
                next_addr <= next_addr + ADDR_W'(1);
                o_valid   <= 1'b1;
            end

            if ((i_stop && state != S_IDLE) || full_hit) begin
                o_fin <= 1'b1;
            end
        end
    end
endmodule
